// File: rtl/alu_pkg.sv
// Shared opcodes, flag bit positions and FSM encoding for the sequential ALU.
package alu_pkg;

  localparam logic [3:0] INS_ADD  = 4'h0;
  localparam logic [3:0] INS_SUB  = 4'h1;
  localparam logic [3:0] INS_AND  = 4'h2;
  localparam logic [3:0] INS_OR   = 4'h3;
  localparam logic [3:0] INS_XOR  = 4'h4;
  localparam logic [3:0] INS_NAND = 4'h5;
  localparam logic [3:0] INS_NOR  = 4'h6;
  localparam logic [3:0] INS_XNOR = 4'h7;
  localparam logic [3:0] INS_NOT  = 4'h8;
  localparam logic [3:0] INS_LSL  = 4'h9;
  localparam logic [3:0] INS_LSR  = 4'hA;
  localparam logic [3:0] INS_ASR  = 4'hB;
  localparam logic [3:0] INS_ROL  = 4'hC;
  localparam logic [3:0] INS_ROR  = 4'hD;
  localparam logic [3:0] INS_ADC  = 4'hE;
  localparam logic [3:0] INS_MUL  = 4'hF;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } aluState_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier, one partial product per clock, WIDTH clocks per product.
module alu_mul_iter #(
  parameter int WIDTH = 8
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic                 iStart,
  input  logic [WIDTH-1:0]     ivA,
  input  logic [WIDTH-1:0]     ivB,
  output logic                 oDone,
  output logic [2*WIDTH-1:0]   ovProducto
);

  localparam int CNTW = $clog2(WIDTH);
  localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

  logic                busy;
  logic [CNTW-1:0]     count;
  logic [WIDTH-1:0]    mcand;
  logic [WIDTH-1:0]    hi;
  logic [WIDTH-1:0]    lo;
  logic [WIDTH-1:0]    addend;
  logic [WIDTH:0]      sumHi;

  // ovProducto is the value {hi,lo} takes at the next edge; on the last
  // iteration it is the finished product, so the top can register it directly.
  always_comb begin
    addend     = lo[0] ? mcand : '0;
    sumHi      = {1'b0, hi} + {1'b0, addend};
    ovProducto = {sumHi, lo[WIDTH-1:1]};
    oDone      = busy && (count == LAST);
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      busy  <= 1'b0;
      count <= '0;
    end else if (iStart) begin
      busy  <= 1'b1;
      count <= '0;
    end else if (busy) begin
      if (count == LAST) busy <= 1'b0;
      else               count <= count + 1'b1;
    end
  end

  always_ff @(posedge iClk) begin
    if (iStart) begin
      mcand <= ivA;
      hi    <= '0;
      lo    <= ivB;
    end else if (busy) begin
      {hi, lo} <= ovProducto;
    end
  end

endmodule

// File: rtl/alu_secuencial_param.sv
// Registered parametric ALU: single-cycle logic/arith/shift ops, stored-carry ADC
// and an iterative MUL behind a valid/ready handshake.
module alu_secuencial_param
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iValid,
  output logic             oReady,
  input  logic [3:0]       ivInstruccion,
  input  logic [WIDTH-1:0] ivRegistroA,
  input  logic [WIDTH-1:0] ivRegistroB,
  output logic             oValid,
  output logic [WIDTH-1:0] ovResultado,
  output logic [WIDTH-1:0] ovResultadoAlto,
  output logic [3:0]       ovFlags
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] W_LIM = WIDTH'(WIDTH);
  localparam int MSB = WIDTH - 1;

  aluState_t            state, nextState;
  logic                 accept;
  logic                 mulStart;
  logic                 mulDone;
  logic                 storedC;
  logic                 adcCarry;
  logic [2*WIDTH-1:0]   producto;
  logic [WIDTH:0]       sum_p0;
  logic [WIDTH:0]       diff_p0;
  logic [WIDTH-1:0]     res_p0;
  logic                 cFlag_p0;
  logic                 vFlag_p0;

  function automatic logic [WIDTH-1:0] shiftRot(input logic [3:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] aS;
    logic [2*WIDTH-1:0]      dbl;
    logic [SHW-1:0]          amt;
    logic                    big;
    aS       = $signed(a);
    dbl      = '0;
    amt      = b[SHW-1:0];
    big      = (b >= W_LIM);
    shiftRot = '0;
    case (op)
      INS_LSL: shiftRot = big ? '0 : (a << b);
      INS_LSR: shiftRot = big ? '0 : (a >> b);
      INS_ASR: shiftRot = big ? {WIDTH{a[MSB]}} : $unsigned(aS >>> b);
      INS_ROL: begin dbl = {a, a} << amt; shiftRot = dbl[2*WIDTH-1:WIDTH]; end
      INS_ROR: begin dbl = {a, a} >> amt; shiftRot = dbl[WIDTH-1:0]; end
      default: shiftRot = '0;
    endcase
  endfunction

  function automatic logic [3:0] packFlags(input logic z, input logic n,
                                           input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

  alu_mul_iter #(.WIDTH(WIDTH)) uMul (
    .iClk       (iClk),
    .iRst_n     (iRst_n),
    .iStart     (mulStart),
    .ivA        (ivRegistroA),
    .ivB        (ivRegistroB),
    .oDone      (mulDone),
    .ovProducto (producto)
  );

  assign accept = iValid && oReady;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) state <= ST_IDLE;
    else         state <= nextState;
  end

  always_comb begin
    nextState = state;
    oReady    = 1'b0;
    mulStart  = 1'b0;
    case (state)
      ST_IDLE: begin
        oReady = 1'b1;
        if (iValid && ivInstruccion == INS_MUL) begin
          mulStart  = 1'b1;
          nextState = ST_MUL;
        end
      end
      ST_MUL: if (mulDone) nextState = ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
  end

  // Stage p0: single-cycle datapath, evaluated on the operands being accepted
  always_comb begin
    adcCarry = (ivInstruccion == INS_ADC) && storedC;
    sum_p0   = {1'b0, ivRegistroA} + {1'b0, ivRegistroB} + {{WIDTH{1'b0}}, adcCarry};
    diff_p0  = {1'b0, ivRegistroA} - {1'b0, ivRegistroB};
    res_p0   = '0;
    cFlag_p0 = 1'b0;
    vFlag_p0 = 1'b0;
    case (ivInstruccion)
      INS_ADD, INS_ADC: begin
        res_p0   = sum_p0[WIDTH-1:0];
        cFlag_p0 = sum_p0[WIDTH];
        vFlag_p0 = (ivRegistroA[MSB] == ivRegistroB[MSB]) && (sum_p0[MSB] != ivRegistroA[MSB]);
      end
      INS_SUB: begin
        res_p0   = diff_p0[WIDTH-1:0];
        cFlag_p0 = diff_p0[WIDTH];
        vFlag_p0 = (ivRegistroA[MSB] != ivRegistroB[MSB]) && (diff_p0[MSB] != ivRegistroA[MSB]);
      end
      INS_AND:  res_p0 = ivRegistroA & ivRegistroB;
      INS_OR:   res_p0 = ivRegistroA | ivRegistroB;
      INS_XOR:  res_p0 = ivRegistroA ^ ivRegistroB;
      INS_NAND: res_p0 = ~(ivRegistroA & ivRegistroB);
      INS_NOR:  res_p0 = ~(ivRegistroA | ivRegistroB);
      INS_XNOR: res_p0 = ~(ivRegistroA ^ ivRegistroB);
      INS_NOT:  res_p0 = ~ivRegistroA;
      INS_LSL, INS_LSR, INS_ASR, INS_ROL, INS_ROR:
        res_p0 = shiftRot(ivInstruccion, ivRegistroA, ivRegistroB);
      default: res_p0 = '0;
    endcase
  end

  // Stage p1: registered results; a MUL completion and a single-cycle accept never coincide
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      ovResultado     <= '0;
      ovResultadoAlto <= '0;
      ovFlags         <= '0;
      oValid          <= 1'b0;
      storedC         <= 1'b0;
    end else begin
      oValid <= 1'b0;
      if (mulDone) begin
        ovResultado     <= producto[WIDTH-1:0];
        ovResultadoAlto <= producto[2*WIDTH-1:WIDTH];
        ovFlags         <= packFlags(producto[WIDTH-1:0] == '0, producto[MSB],
                                     |producto[2*WIDTH-1:WIDTH], 1'b0);
        storedC         <= |producto[2*WIDTH-1:WIDTH];
        oValid          <= 1'b1;
      end else if (accept && ivInstruccion != INS_MUL) begin
        ovResultado     <= res_p0;
        ovResultadoAlto <= '0;
        ovFlags         <= packFlags(res_p0 == '0, res_p0[MSB], cFlag_p0, vFlag_p0);
        storedC         <= cFlag_p0;
        oValid          <= 1'b1;
      end
    end
  end

endmodule
